// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), even parity, 1 stop.
// Mid-bit sampling of a two-flop synchronised line; rx_ready strobes one cycle per frame.
module uart_rx #(
  parameter int Clkperbaud = 1250
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       rx_serial,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       framing_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(Clkperbaud);
  localparam logic [CW-1:0] LAST_CNT = CW'(Clkperbaud - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(Clkperbaud / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_DONE   = 3'd5,
    S_BREAK  = 3'd6
  } state_t;

  // Even parity across data and parity bit; 1 means the received frame is inconsistent.
  function automatic logic f_parity_err(input logic [7:0] data, input logic p_bit);
    return ^{data, p_bit};
  endfunction

  state_t          r_state;
  logic [CW-1:0]   r_clk_count;
  logic [2:0]      r_bit_index;
  logic [7:0]      r_shift;
  logic            r_p_bit;
  logic            r_sync1;
  logic            r_sync2;
  logic [7:0]      r_rx_byte;
  logic            r_rx_ready;
  logic            r_parity_err;
  logic            r_framing_err;
  logic            r_rx_busy;
  logic            w_rx_s;

  assign w_rx_s      = r_sync2;
  assign rx_byte     = r_rx_byte;
  assign rx_ready    = r_rx_ready;
  assign parity_err  = r_parity_err;
  assign framing_err = r_framing_err;
  assign rx_busy     = r_rx_busy;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_serial;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM with registered outputs; counters clear on every state change.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state       <= S_IDLE;
      r_clk_count   <= CNT_ZERO;
      r_bit_index   <= 3'd0;
      r_shift       <= 8'h00;
      r_p_bit       <= 1'b0;
      r_rx_byte     <= 8'h00;
      r_rx_ready    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_framing_err <= 1'b0;
      r_rx_busy     <= 1'b0;
    end else begin
      r_rx_ready <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_count <= CNT_ZERO;
          r_bit_index <= 3'd0;
          if (!w_rx_s) begin
            r_state   <= S_START;
            r_rx_busy <= 1'b1;
          end else begin
            r_rx_busy <= 1'b0;
          end
        end

        S_START: begin
          if (r_clk_count == HALF_CNT) begin
            r_clk_count <= CNT_ZERO;
            if (!w_rx_s) begin
              r_state <= S_DATA;
            end else begin
              r_state   <= S_IDLE;
              r_rx_busy <= 1'b0;
            end
          end else begin
            r_clk_count <= r_clk_count + CNT_ONE;
          end
        end

        S_DATA: begin
          if (r_clk_count == LAST_CNT) begin
            r_clk_count          <= CNT_ZERO;
            r_shift[r_bit_index] <= w_rx_s;
            if (r_bit_index == 3'd7) begin
              r_bit_index <= 3'd0;
              r_state     <= S_PARITY;
            end else begin
              r_bit_index <= r_bit_index + 3'd1;
            end
          end else begin
            r_clk_count <= r_clk_count + CNT_ONE;
          end
        end

        S_PARITY: begin
          if (r_clk_count == LAST_CNT) begin
            r_clk_count <= CNT_ZERO;
            r_p_bit     <= w_rx_s;
            r_state     <= S_STOP;
          end else begin
            r_clk_count <= r_clk_count + CNT_ONE;
          end
        end

        S_STOP: begin
          if (r_clk_count == LAST_CNT) begin
            r_clk_count   <= CNT_ZERO;
            r_rx_byte     <= r_shift;
            r_parity_err  <= f_parity_err(r_shift, r_p_bit);
            r_framing_err <= ~w_rx_s;
            r_rx_ready    <= 1'b1;
            r_state       <= S_DONE;
          end else begin
            r_clk_count <= r_clk_count + CNT_ONE;
          end
        end

        S_DONE: begin
          r_clk_count <= CNT_ZERO;
          r_bit_index <= 3'd0;
          if (r_framing_err) begin
            r_state <= S_BREAK;
          end else begin
            r_state   <= S_IDLE;
            r_rx_busy <= 1'b0;
          end
        end

        // A line held low after a bad stop bit must go high before a new start is accepted.
        S_BREAK: begin
          r_clk_count <= CNT_ZERO;
          r_bit_index <= 3'd0;
          if (w_rx_s) begin
            r_state   <= S_IDLE;
            r_rx_busy <= 1'b0;
          end else begin
            r_state <= S_BREAK;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_clk_count <= CNT_ZERO;
          r_bit_index <= 3'd0;
          r_rx_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

  localparam int C = 16;

  logic       clk = 1'b0;
  logic       Rst;
  logic       rx_serial;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       parity_err;
  logic       framing_err;
  logic       rx_busy;

  int n_assert = 0;
  int n_fail   = 0;

  int cyc = 0;
  int ready_cnt = 0;
  int busy_hi_cnt = 0;
  int busy_rise_cyc = 0;
  logic busy_prev = 1'b0;
  logic [7:0] got_byte [0:63];
  logic       got_perr [0:63];
  logic       got_ferr [0:63];
  int         got_lat  [0:63];

  uart_rx #(.Clkperbaud(C)) dut (
    .clk        (clk),
    .Rst        (Rst),
    .rx_serial  (rx_serial),
    .rx_byte    (rx_byte),
    .rx_ready   (rx_ready),
    .parity_err (parity_err),
    .framing_err(framing_err),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every rx_ready strobe and busy activity, sampled away from the active edge.
  always @(negedge clk) begin
    busy_prev <= rx_busy;
    if (rx_busy && !busy_prev) busy_rise_cyc <= cyc;
    if (rx_busy) busy_hi_cnt <= busy_hi_cnt + 1;
    if (rx_ready) begin
      got_byte[ready_cnt] <= rx_byte;
      got_perr[ready_cnt] <= parity_err;
      got_ferr[ready_cnt] <= framing_err;
      got_lat[ready_cnt]  <= cyc - busy_rise_cyc;
      ready_cnt           <= ready_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (C) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level when done.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  logic [7:0] vec [0:7];
  int r0;
  int b0;

  initial begin
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h55; vec[3] = 8'hAA;
    vec[4] = 8'h01; vec[5] = 8'h80; vec[6] = 8'h48; vec[7] = 8'h69;
    Rst = 1'b1;
    rx_serial = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_byte", {24'd0, rx_byte}, 32'h00);
    chk("rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_perr", {31'd0, parity_err}, 32'd0);
    chk("rst_ferr", {31'd0, framing_err}, 32'd0);
    chk("rst_busy", {31'd0, rx_busy}, 32'd0);
    Rst = 1'b0;
    repeat (5) @(negedge clk);

    // Clean frame 0xA5, latency from start detect to rx_ready
    r0 = ready_cnt;
    send_frame(8'hA5, 1'b0, 1'b1);
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    chk("a5_count", ready_cnt - r0, 32'd1);
    chk("a5_byte", {24'd0, got_byte[r0]}, 32'hA5);
    chk("a5_perr", {31'd0, got_perr[r0]}, 32'd0);
    chk("a5_ferr", {31'd0, got_ferr[r0]}, 32'd0);
    chk("a5_latency", got_lat[r0], 32'd168);
    chk("a5_held", {24'd0, rx_byte}, 32'hA5);
    chk("a5_idle_busy", {31'd0, rx_busy}, 32'd0);

    // Parity good then bad
    r0 = ready_cnt;
    send_frame(8'h07, 1'b1, 1'b1);
    send_frame(8'h07, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("par_count", ready_cnt - r0, 32'd2);
    chk("par_good_byte", {24'd0, got_byte[r0]}, 32'h07);
    chk("par_good_perr", {31'd0, got_perr[r0]}, 32'd0);
    chk("par_bad_byte", {24'd0, got_byte[r0+1]}, 32'h07);
    chk("par_bad_perr", {31'd0, got_perr[r0+1]}, 32'd1);

    // Framing error with the line held low afterwards
    r0 = ready_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    chk("frm_count", ready_cnt - r0, 32'd1);
    chk("frm_byte", {24'd0, got_byte[r0]}, 32'h3C);
    chk("frm_ferr", {31'd0, got_ferr[r0]}, 32'd1);
    chk("frm_perr", {31'd0, got_perr[r0]}, 32'd0);
    chk("frm_break_busy", {31'd0, rx_busy}, 32'd1);
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    chk("frm_release_busy", {31'd0, rx_busy}, 32'd0);
    chk("frm_no_retrigger", ready_cnt - r0, 32'd1);
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("frm_next_count", ready_cnt - r0, 32'd2);
    chk("frm_next_byte", {24'd0, got_byte[r0+1]}, 32'h81);
    chk("frm_next_ferr", {31'd0, got_ferr[r0+1]}, 32'd0);

    // Short low glitch on an idle line
    r0 = ready_cnt;
    b0 = busy_hi_cnt;
    rx_serial = 1'b0;
    repeat (5) @(negedge clk);
    rx_serial = 1'b1;
    repeat (3 * C) @(negedge clk);
    chk("glitch_no_ready", ready_cnt - r0, 32'd0);
    chk("glitch_byte_held", {24'd0, rx_byte}, 32'h81);
    chk("glitch_busy_len", busy_hi_cnt - b0, 32'd8);
    chk("glitch_busy_end", {31'd0, rx_busy}, 32'd0);

    // Reset during data bit 4, then a clean 0x5A
    r0 = ready_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0]);
    rx_serial = 1'b1;
    repeat (5) @(negedge clk);
    Rst = 1'b1;
    #1;
    chk("mid_rst_byte", {24'd0, rx_byte}, 32'h00);
    chk("mid_rst_ready", {31'd0, rx_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, rx_busy}, 32'd0);
    chk("mid_rst_perr", {31'd0, parity_err}, 32'd0);
    chk("mid_rst_ferr", {31'd0, framing_err}, 32'd0);
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    repeat (2 * C) @(negedge clk);
    chk("mid_rst_no_ready", ready_cnt - r0, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_rst_count", ready_cnt - r0, 32'd1);
    chk("post_rst_byte", {24'd0, got_byte[r0]}, 32'h5A);
    chk("post_rst_perr", {31'd0, got_perr[r0]}, 32'd0);
    chk("post_rst_ferr", {31'd0, got_ferr[r0]}, 32'd0);

    // Eight back-to-back frames with no idle gap
    r0 = ready_cnt;
    for (int i = 0; i < 8; i++) send_frame(vec[i], ^vec[i], 1'b1);
    rx_serial = 1'b1;
    repeat (4) @(negedge clk);
    chk("b2b_count", ready_cnt - r0, 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b_byte%0d", i), {24'd0, got_byte[r0+i]}, {24'd0, vec[i]});
      chk($sformatf("b2b_perr%0d", i), {31'd0, got_perr[r0+i]}, 32'd0);
      chk($sformatf("b2b_ferr%0d", i), {31'd0, got_ferr[r0+i]}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the downstream counterpart of the team's uart_tx, on the far side of the serial link.
- Frame format matches uart_tx:
  - 1 start bit (0)
  - 8 data bits, LSB first
  - 1 even-parity bit (set so total ones in data+parity is even)
  - 1 stop bit (1)
- Oversamples the line with the system clock, samples each bit at mid-period, and presents the recovered byte plus parity and framing status to the game logic as a one-cycle strobe.

Parameters:
- Clkperbaud, 1250, system clock cycles per bit period; must be ≥ 4.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- Rst  input  1  asynchronous, active-high reset.
- rx_serial  input  1  asynchronous serial line, idle high.
- rx_byte  output  8  last received data byte; held until the next frame completes.
- rx_ready  output  1  one-cycle pulse: frame complete, rx_byte/parity_err/framing_err valid.
- parity_err  output  1  valid with rx_ready; 1 = parity mismatch; held with rx_byte.
- framing_err  output  1  valid with rx_ready; 1 = stop bit sampled 0; held with rx_byte.
- rx_busy  output  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset (async, Rst=1):
  - State IDLE; counters 0.
  - Both synchronizer flops = 1.
  - Shift register 0, rx_byte=8'h00, rx_ready=0, parity_err=0, framing_err=0, rx_busy=0.
- Input sync: rx_serial passes through 2 flops; rx_s = second flop. All decisions use rx_s only.
- Counter: clk_count, width $clog2(Clkperbaud); bit_index 3 bits. Both clear on every state change.
- States and transitions:
  - IDLE: rx_busy=0. rx_s==0 -> START, clk_count=0. The cycle rx_s is first seen 0 is t0.
  - START: count to Clkperbaud/2 - 1 (integer division); at terminal count sample rx_s.
    - rx_s==0 -> DATA.
    - rx_s==1 -> glitch; back to IDLE; no rx_ready; outputs unchanged.
  - DATA: count to Clkperbaud-1; at terminal count shift rx_s into bit[bit_index].
    - bit_index<7: increment.
    - bit_index==7: -> PARITY.
  - PARITY: count to Clkperbaud-1; at terminal count latch p_bit = rx_s -> STOP.
  - STOP: count to Clkperbaud-1; at terminal count:
    - rx_byte <= shift register.
    - parity_err <= XOR of 8 data bits and p_bit.
    - framing_err <= ~rx_s.
    - -> DONE.
  - DONE: rx_ready=1 for exactly this cycle.
    - framing_err==0 -> IDLE.
    - framing_err==1 -> BREAK.
  - BREAK: wait until rx_s==1, then -> IDLE. Prevents a held-low line re-triggering START.
  - Undefined state encodings -> IDLE.
- Sample timing:
  - Data bit k (k=0..7) sampled at t0 + Clkperbaud/2 + (k+1)*Clkperbaud.
  - Parity sampled at t0 + Clkperbaud/2 + 9*Clkperbaud.
  - Stop sampled at t0 + Clkperbaud/2 + 10*Clkperbaud.
  - rx_ready high in the cycle after the stop sample.
- rx_busy=1 in START, DATA, PARITY, STOP, DONE and BREAK.
- Errors: a frame with errors still updates rx_byte and pulses rx_ready; the consumer decides whether to discard it.
- Back-to-back frames: a start edge arriving during DONE is detected in IDLE on the next cycle. The half-bit margin after the stop sample absorbs this one-cycle delay.
- Reset mid-frame: partial byte discarded, no rx_ready pulse, all outputs return to reset values immediately.

Test Plan:
- Clkperbaud=16, send 8'hA5 with parity 0 and stop 1 -> single rx_ready pulse at t0+168; rx_byte=8'hA5, parity_err=0, framing_err=0.
- Send 8'h07 (3 ones) with correct parity 1, then the same byte with parity 0 -> first frame parity_err=0, second parity_err=1, rx_byte=8'h07 both times.
- Send 8'h3C with stop bit 0, line held low 40 cycles -> rx_ready with framing_err=1; no second rx_ready until the line returns high and a new start bit arrives.
- 5-cycle low glitch on idle line -> return to IDLE, no rx_ready, rx_byte unchanged, rx_busy high for Clkperbaud/2 cycles only.
- Assert Rst during bit 4 of a frame, then send 8'h5A cleanly -> outputs zero during reset; next rx_ready delivers 8'h5A with no errors.
- Loopback to uart_tx, 8 back-to-back bytes 8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h48, 8'h69 -> 8 rx_ready pulses with matching bytes and all error flags 0.
